// File: rtl/noc_local_interface_if.sv
// Bundles the host-side and router-side handshake signals of the local network interface.
// The master modport is the interface block; the slave modport is its environment (host and router).
interface noc_local_interface_if;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [3:0]  tx_dest_x_i;
  logic [3:0]  tx_dest_y_i;
  logic [7:0]  tx_payload_i;
  logic [15:0] inj_data_o;
  logic        inj_enable_o;
  logic        inj_credit_i;
  logic [15:0] ej_data_i;
  logic        ej_enable_i;
  logic        ej_credit_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [7:0]  rx_payload_o;
  logic        rx_misroute_o;
  logic        rx_overflow_o;
  logic        credit_err_o;

  modport master (
    input  tx_valid_i, tx_dest_x_i, tx_dest_y_i, tx_payload_i,
    input  inj_credit_i, ej_data_i, ej_enable_i, rx_ready_i,
    output tx_ready_o, inj_data_o, inj_enable_o, ej_credit_o,
    output rx_valid_o, rx_payload_o, rx_misroute_o, rx_overflow_o, credit_err_o
  );

  modport slave (
    output tx_valid_i, tx_dest_x_i, tx_dest_y_i, tx_payload_i,
    output inj_credit_i, ej_data_i, ej_enable_i, rx_ready_i,
    input  tx_ready_o, inj_data_o, inj_enable_o, ej_credit_o,
    input  rx_valid_o, rx_payload_o, rx_misroute_o, rx_overflow_o, credit_err_o
  );
endinterface

// File: rtl/noc_local_interface.sv
// Network interface between a local host and a router's L port: credit-controlled flit
// injection plus a first-word fall-through eject FIFO that returns one credit per consumed flit.
module noc_local_interface #(
  parameter int XCOORD   = 0,
  parameter int YCOORD   = 0,
  parameter int CREDITS  = 4,
  parameter int RX_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  noc_local_interface_if.master bus
);

  localparam int              PTR_W     = $clog2(RX_DEPTH);
  localparam logic [3:0]      CREDITS_C = 4'(CREDITS);
  localparam logic [PTR_W:0]  DEPTH_C   = (PTR_W + 1)'(RX_DEPTH);
  localparam logic [7:0]      HOME      = {4'(XCOORD), 4'(YCOORD)};

  logic [3:0]       credit_cnt_q, credit_cnt_d;
  logic             credit_err_q, credit_err_d;
  logic [15:0]      inj_data_q, inj_data_d;
  logic             inj_enable_q, inj_enable_d;
  logic             ej_credit_q, ej_credit_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      mem_q [RX_DEPTH];
  logic [15:0]      mem_d [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic        tx_ready;
  logic        fire;
  logic        rx_valid;
  logic        pop;
  logic        push;
  logic [15:0] head;

  assign tx_ready = (credit_cnt_q != 4'd0);
  assign fire     = bus.tx_valid_i & tx_ready;
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid & bus.rx_ready_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = bus.ej_enable_i & ((count_q < DEPTH_C) | pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    case ({fire, bus.inj_credit_i})
      2'b10:   credit_cnt_d = credit_cnt_q - 4'd1;
      2'b01: begin
        if (credit_cnt_q == CREDITS_C) credit_err_d = 1'b1;
        else                           credit_cnt_d = credit_cnt_q + 4'd1;
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase

    inj_enable_d = fire;
    inj_data_d   = fire ? {bus.tx_payload_i, bus.tx_dest_x_i, bus.tx_dest_y_i} : inj_data_q;
    ej_credit_d  = pop;
    overflow_d   = overflow_q | (bus.ej_enable_i & ~push);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.ej_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_q <= CREDITS_C;
      credit_err_q <= 1'b0;
      inj_data_q   <= 16'd0;
      inj_enable_q <= 1'b0;
      ej_credit_q  <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= 16'd0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      inj_data_q   <= inj_data_d;
      inj_enable_q <= inj_enable_d;
      ej_credit_q  <= ej_credit_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.tx_ready_o    = tx_ready;
  assign bus.inj_data_o    = inj_data_q;
  assign bus.inj_enable_o  = inj_enable_q;
  assign bus.ej_credit_o   = ej_credit_q;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.rx_payload_o  = head[15:8];
  assign bus.rx_misroute_o = (head[7:0] != HOME);
  assign bus.rx_overflow_o = overflow_q;
  assign bus.credit_err_o  = credit_err_q;

endmodule

// File: tb/tb_noc_local_interface.sv
// Directed and random stimulus for the local network interface, checked every cycle
// against a transaction-level model (credit count, flit queue, pending pulses).
module tb_noc_local_interface;

  localparam int XC = 1;
  localparam int YC = 1;
  localparam int CR = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  noc_local_interface_if bus();

  noc_local_interface #(.XCOORD(XC), .YCOORD(YC), .CREDITS(CR), .RX_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;

  int          m_credits;
  logic [15:0] m_queue [$];
  logic        m_inj_en;
  logic [15:0] m_inj_data;
  logic        m_ej_credit;
  logic        m_ovf;
  logic        m_cerr;

  int pulses;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_credits   = CR;
    m_queue.delete();
    m_inj_en    = 1'b0;
    m_inj_data  = 16'd0;
    m_ej_credit = 1'b0;
    m_ovf       = 1'b0;
    m_cerr      = 1'b0;
  endtask

  // Advance the model by one clock from the inputs that were just sampled.
  task automatic modelStep();
    logic f, p, c;
    if (rst) begin
      modelReset();
      return;
    end
    f = bus.tx_valid_i && (m_credits > 0);
    p = bus.rx_ready_i && (m_queue.size() > 0);
    c = bus.inj_credit_i;
    if (f && !c) m_credits--;
    else if (c && !f) begin
      if (m_credits == CR) m_cerr = 1'b1;
      else m_credits++;
    end
    m_inj_en = f;
    if (f) m_inj_data = {bus.tx_payload_i, bus.tx_dest_x_i, bus.tx_dest_y_i};
    m_ej_credit = p;
    if (p) void'(m_queue.pop_front());
    if (bus.ej_enable_i) begin
      if (m_queue.size() < DEPTH) m_queue.push_back(bus.ej_data_i);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic checkOutput();
    chk("tx_ready",   16'(bus.tx_ready_o),    16'(m_credits != 0));
    chk("inj_enable", 16'(bus.inj_enable_o),  16'(m_inj_en));
    chk("inj_data",   bus.inj_data_o,         m_inj_data);
    chk("ej_credit",  16'(bus.ej_credit_o),   16'(m_ej_credit));
    chk("rx_valid",   16'(bus.rx_valid_o),    16'(m_queue.size() != 0));
    chk("overflow",   16'(bus.rx_overflow_o), 16'(m_ovf));
    chk("credit_err", 16'(bus.credit_err_o),  16'(m_cerr));
    if (m_queue.size() != 0) begin
      chk("rx_payload",  16'(bus.rx_payload_o),  16'(m_queue[0][15:8]));
      chk("rx_misroute", 16'(bus.rx_misroute_o), 16'(m_queue[0][7:4] != 4'(XC) || m_queue[0][3:0] != 4'(YC)));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic tv, input logic [3:0] dx, input logic [3:0] dy,
                               input logic [7:0] pl, input logic cr, input logic ee,
                               input logic [15:0] ed, input logic rr);
    rst              = r;
    bus.tx_valid_i   = tv;
    bus.tx_dest_x_i  = dx;
    bus.tx_dest_y_i  = dy;
    bus.tx_payload_i = pl;
    bus.inj_credit_i = cr;
    bus.ej_enable_i  = ee;
    bus.ej_data_i    = ed;
    bus.rx_ready_i   = rr;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 0);
  endtask

  task automatic credit();
    applyStimulus(0, 0, 4'd0, 4'd0, 8'd0, 1, 0, 16'd0, 0);
  endtask

  task automatic pushFlit(input logic [15:0] f, input logic rr);
    applyStimulus(0, 0, 4'd0, 4'd0, 8'd0, 0, 1, f, rr);
  endtask

  initial begin
    modelReset();
    applyStimulus(1, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 0);
    applyStimulus(1, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 0);

    // Six back-to-back inject requests with no credits returned.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 4'd2, 4'd3, 8'hA5, 0, 0, 16'd0, 0);
      if (bus.inj_enable_o) pulses++;
    end
    chk("inj_pulse_count", 16'(pulses), 16'd4);
    chk("inj_data_a523", bus.inj_data_o, 16'hA523);
    chk("tx_ready_empty", 16'(bus.tx_ready_o), 16'd0);

    // One credit returned at zero while the host keeps requesting.
    applyStimulus(0, 1, 4'd5, 4'd6, 8'h3C, 1, 0, 16'd0, 0);
    applyStimulus(0, 1, 4'd5, 4'd6, 8'h3C, 0, 0, 16'd0, 0);
    applyStimulus(0, 1, 4'd5, 4'd6, 8'h3C, 0, 0, 16'd0, 0);
    idle();

    // Credit and fire together at two credits, then one credit too many.
    credit();
    credit();
    applyStimulus(0, 1, 4'd7, 4'd1, 8'h42, 1, 0, 16'd0, 0);
    credit();
    credit();
    credit();
    chk("credit_err_set", 16'(bus.credit_err_o), 16'd1);
    idle();

    // Three flits, the last one addressed elsewhere, then drained.
    pushFlit(16'h1111, 0);
    pushFlit(16'h2211, 0);
    pushFlit(16'h3312, 0);
    chk("head_payload_11", 16'(bus.rx_payload_o), 16'h11);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 1);

    // Fill, overflow on a fifth write, then a fifth write alongside a pop.
    for (int i = 0; i < 4; i++) pushFlit(16'h4011 + 16'(i << 8), 0);
    pushFlit(16'h9911, 0);
    chk("overflow_set", 16'(bus.rx_overflow_o), 16'd1);
    pushFlit(16'h5512, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 1);

    // Reset with an inject pulse pending and two flits buffered.
    applyStimulus(1, 0, 4'd0, 4'd0, 8'd0, 0, 0, 16'd0, 0);
    pushFlit(16'h6611, 0);
    pushFlit(16'h7711, 0);
    applyStimulus(0, 1, 4'd3, 4'd3, 8'h77, 0, 0, 16'd0, 0);
    applyStimulus(1, 1, 4'd3, 4'd3, 8'h78, 0, 1, 16'h8811, 1);
    chk("rst_inj_enable", 16'(bus.inj_enable_o), 16'd0);
    chk("rst_rx_valid", 16'(bus.rx_valid_o), 16'd0);
    chk("rst_ej_credit", 16'(bus.ej_credit_o), 16'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom),
                    ($urandom_range(0, 2) == 0),
                    1'($urandom),
                    ($urandom_range(0, 1) == 0) ? {8'($urandom), 4'(XC), 4'(YC)} : 16'($urandom),
                    ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
